// File: rtl/cpu_cu.sv
// ---------------------------------------------------------------------------
// cpu_cu -- control unit for the CPU execution unit (EU).
//
// Runs every instruction as three cycles: FETCH, DECODE, EX. Every control
// output is a combinational decode of the current state and the instruction
// register, so an asynchronous reset drops all of them immediately. The only
// storage is the state register and the latched ALU flags {C,N,Z}. The
// latched flags, not the live EU flags, decide conditional branches.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous reset, active low
//   ir[15:0]   in   instruction register contents from the EU
//   C, N, Z    in   live ALU carry / negative / zero from the EU
//   ir_ld      out  load instruction register
//   pc_inc     out  increment PC
//   pc_ld      out  load PC from the PC mux
//   pc_sel     out  PC mux: 1 = D_out, 0 = PC + sext(ir[7:0])
//   adr_sel    out  address mux: 1 = register address, 0 = PC
//   W_En       out  register-file write enable
//   S_Sel      out  S operand: 1 = memory data, 0 = register
//   W_Adr[2:0] out  register-file write address
//   R_Adr[2:0] out  register-file R read address
//   S_Adr[2:0] out  register-file S read address
//   Alu_Op[3:0] out ALU operation
//   mr_en      out  memory read enable
//   mw_en      out  memory write enable
//   instr_done out  one-cycle pulse when an instruction retires
//   illegal    out  sticky illegal-opcode indicator
//   dbg_state  out  current FSM state encoding
// ---------------------------------------------------------------------------
module cpu_cu #(
    parameter logic [3:0] ALU_PASS_S       = 4'h0,
    parameter logic [3:0] RESET_STATE_CODE = 4'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ir,
    input  logic        C,
    input  logic        N,
    input  logic        Z,
    output logic        ir_ld,
    output logic        pc_inc,
    output logic        pc_ld,
    output logic        pc_sel,
    output logic        adr_sel,
    output logic        W_En,
    output logic        S_Sel,
    output logic [2:0]  W_Adr,
    output logic [2:0]  R_Adr,
    output logic [2:0]  S_Adr,
    output logic [3:0]  Alu_Op,
    output logic        mr_en,
    output logic        mw_en,
    output logic        instr_done,
    output logic        illegal,
    output logic [3:0]  dbg_state
);

    localparam logic [3:0] ST_RESET   = RESET_STATE_CODE;
    localparam logic [3:0] ST_FETCH   = 4'h1;
    localparam logic [3:0] ST_DECODE  = 4'h2;
    localparam logic [3:0] ST_EX_ALU  = 4'h3;
    localparam logic [3:0] ST_EX_LD   = 4'h4;
    localparam logic [3:0] ST_EX_ST   = 4'h5;
    localparam logic [3:0] ST_EX_BR   = 4'h6;
    localparam logic [3:0] ST_EX_JR   = 4'h7;
    localparam logic [3:0] ST_HALT    = 4'h8;
    localparam logic [3:0] ST_ILLEGAL = 4'h9;

    localparam logic [6:0] OP_LD   = 7'h10;
    localparam logic [6:0] OP_ST   = 7'h11;
    localparam logic [6:0] OP_BR   = 7'h20;
    localparam logic [6:0] OP_BEQ  = 7'h21;
    localparam logic [6:0] OP_BNE  = 7'h22;
    localparam logic [6:0] OP_BC   = 7'h23;
    localparam logic [6:0] OP_BN   = 7'h24;
    localparam logic [6:0] OP_JR   = 7'h28;
    localparam logic [6:0] OP_HALT = 7'h7F;

    logic [3:0] state_q, state_d;
    logic [2:0] flags_q, flags_d;   // {C, N, Z}

    logic [6:0] op;
    logic [2:0] wa, ra, sa;
    logic       br_taken;

    assign op = ir[15:9];
    assign wa = ir[8:6];
    assign ra = ir[5:3];
    assign sa = ir[2:0];

    // Branch condition on the latched flags; BR is unconditional.
    always_comb begin
        br_taken = 1'b0;
        case (op)
            OP_BR:   br_taken = 1'b1;
            OP_BEQ:  br_taken = flags_q[0];
            OP_BNE:  br_taken = ~flags_q[0];
            OP_BC:   br_taken = flags_q[2];
            OP_BN:   br_taken = flags_q[1];
            default: br_taken = 1'b0;
        endcase
    end

    // State and flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RESET;
            flags_q <= 3'b000;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    // Next-state and flag-update logic.
    always_comb begin
        state_d = ST_RESET;
        flags_d = flags_q;
        case (state_q)
            ST_RESET:  state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                if (op[6:4] == 3'b000) begin
                    state_d = ST_EX_ALU;
                end else begin
                    case (op)
                        OP_LD:   state_d = ST_EX_LD;
                        OP_ST:   state_d = ST_EX_ST;
                        OP_BR, OP_BEQ, OP_BNE, OP_BC, OP_BN:
                                 state_d = ST_EX_BR;
                        OP_JR:   state_d = ST_EX_JR;
                        OP_HALT: state_d = ST_HALT;
                        default: state_d = ST_ILLEGAL;
                    endcase
                end
            end
            ST_EX_ALU: begin
                state_d = ST_FETCH;
                flags_d = {C, N, Z};
            end
            ST_EX_LD, ST_EX_ST, ST_EX_BR, ST_EX_JR:
                       state_d = ST_FETCH;
            ST_HALT:    state_d = ST_HALT;
            ST_ILLEGAL: state_d = ST_ILLEGAL;
            default:    state_d = ST_RESET;
        endcase
    end

    // Output decode: everything defaults to 0, each state raises its set.
    always_comb begin
        ir_ld      = 1'b0;
        pc_inc     = 1'b0;
        pc_ld      = 1'b0;
        pc_sel     = 1'b0;
        adr_sel    = 1'b0;
        W_En       = 1'b0;
        S_Sel      = 1'b0;
        W_Adr      = 3'd0;
        R_Adr      = 3'd0;
        S_Adr      = 3'd0;
        Alu_Op     = 4'h0;
        mr_en      = 1'b0;
        mw_en      = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mr_en  = 1'b1;
                ir_ld  = 1'b1;
                pc_inc = 1'b1;
            end
            ST_DECODE: begin
                W_Adr = wa;
                R_Adr = ra;
                S_Adr = sa;
            end
            ST_EX_ALU: begin
                W_En       = 1'b1;
                Alu_Op     = op[3:0];
                W_Adr      = wa;
                R_Adr      = ra;
                S_Adr      = sa;
                instr_done = 1'b1;
            end
            ST_EX_LD: begin
                adr_sel    = 1'b1;
                R_Adr      = ra;
                mr_en      = 1'b1;
                S_Sel      = 1'b1;
                Alu_Op     = ALU_PASS_S;
                W_En       = 1'b1;
                W_Adr      = wa;
                instr_done = 1'b1;
            end
            ST_EX_ST: begin
                adr_sel    = 1'b1;
                R_Adr      = ra;
                S_Adr      = sa;
                Alu_Op     = ALU_PASS_S;
                mw_en      = 1'b1;
                instr_done = 1'b1;
            end
            ST_EX_BR: begin
                pc_ld      = br_taken;
                instr_done = 1'b1;
            end
            ST_EX_JR: begin
                S_Adr      = sa;
                Alu_Op     = ALU_PASS_S;
                pc_sel     = 1'b1;
                pc_ld      = 1'b1;
                instr_done = 1'b1;
            end
            ST_ILLEGAL: illegal = 1'b1;
            default: ;
        endcase
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_cpu_cu.sv
// ---------------------------------------------------------------------------
// tb_cpu_cu -- directed bench for cpu_cu.
//
// The driver sets ir / C / N / Z just after each rising edge and pushes the
// hand-computed control word for that cycle onto exp_q. The monitor, on each
// falling edge, pops one entry and compares it with the DUT outputs, and also
// checks the pc_inc/pc_ld, mr_en/mw_en and W_En/mw_en exclusions.
// ---------------------------------------------------------------------------
module tb_cpu_cu;

    typedef struct packed {
        logic       ir_ld;
        logic       pc_inc;
        logic       pc_ld;
        logic       pc_sel;
        logic       adr_sel;
        logic       w_en;
        logic       s_sel;
        logic [2:0] w_adr;
        logic [2:0] r_adr;
        logic [2:0] s_adr;
        logic [3:0] alu_op;
        logic       mr_en;
        logic       mw_en;
        logic       instr_done;
        logic       illegal;
        logic [3:0] st;
    } ctl_t;

    localparam int W = $bits(ctl_t);

    logic        clk;
    logic        reset;
    logic [15:0] ir;
    logic        C, N, Z;
    logic        ir_ld, pc_inc, pc_ld, pc_sel, adr_sel, W_En, S_Sel;
    logic [2:0]  W_Adr, R_Adr, S_Adr;
    logic [3:0]  Alu_Op;
    logic        mr_en, mw_en, instr_done, illegal;
    logic [3:0]  dbg_state;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           checks = 0;
    int           errors = 0;

    cpu_cu dut (
        .clk        (clk),
        .reset      (reset),
        .ir         (ir),
        .C          (C),
        .N          (N),
        .Z          (Z),
        .ir_ld      (ir_ld),
        .pc_inc     (pc_inc),
        .pc_ld      (pc_ld),
        .pc_sel     (pc_sel),
        .adr_sel    (adr_sel),
        .W_En       (W_En),
        .S_Sel      (S_Sel),
        .W_Adr      (W_Adr),
        .R_Adr      (R_Adr),
        .S_Adr      (S_Adr),
        .Alu_Op     (Alu_Op),
        .mr_en      (mr_en),
        .mw_en      (mw_en),
        .instr_done (instr_done),
        .illegal    (illegal),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached, got %0d checks required completion", checks);
        $fatal(1, "time limit");
    end

    // ---------------- monitor / scoreboard ----------------
    ctl_t act;
    assign act = '{ir_ld, pc_inc, pc_ld, pc_sel, adr_sel, W_En, S_Sel,
                   W_Adr, R_Adr, S_Adr, Alu_Op, mr_en, mw_en, instr_done,
                   illegal, dbg_state};

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            string        nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %07h required %07h (state got %0d required %0d)",
                         nm, act, e, dbg_state, e[3:0]);
            end
            checks++;
            if ((pc_inc && pc_ld) || (mr_en && mw_en) || (W_En && mw_en)) begin
                errors++;
                $display("FAIL %s_exclusive: pc_inc=%b pc_ld=%b mr_en=%b mw_en=%b W_En=%b required no overlap",
                         nm, pc_inc, pc_ld, mr_en, mw_en, W_En);
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic ctl_t blank(input logic [3:0] st);
        ctl_t r;
        r    = '0;
        r.st = st;
        return r;
    endfunction

    task automatic expect_cycle(input ctl_t e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input logic [15:0] v, input logic [2:0] wa,
                                input logic [2:0] ra, input logic [2:0] sa,
                                input string nm);
        ctl_t e;
        ir       = v;
        e        = blank(4'd1);
        e.ir_ld  = 1'b1;
        e.pc_inc = 1'b1;
        e.mr_en  = 1'b1;
        expect_cycle(e, {nm, "_fetch"});
        e       = blank(4'd2);
        e.w_adr = wa;
        e.r_adr = ra;
        e.s_adr = sa;
        expect_cycle(e, {nm, "_decode"});
    endtask

    function automatic ctl_t alu_word(input logic [2:0] wa, input logic [2:0] ra,
                                      input logic [2:0] sa, input logic [3:0] op4);
        ctl_t e;
        e            = blank(4'd3);
        e.w_en       = 1'b1;
        e.alu_op     = op4;
        e.w_adr      = wa;
        e.r_adr      = ra;
        e.s_adr      = sa;
        e.instr_done = 1'b1;
        return e;
    endfunction

    // ALU instruction; c/n/z are the live EU flags during EX_ALU.
    task automatic do_alu(input logic [15:0] v, input logic [2:0] wa, input logic [2:0] ra,
                          input logic [2:0] sa, input logic [3:0] op4,
                          input logic c, input logic n, input logic z, input string nm);
        fetch_decode(v, wa, ra, sa, nm);
        C = c; N = n; Z = z;
        expect_cycle(alu_word(wa, ra, sa, op4), {nm, "_ex"});
    endtask

    // Branch; live flags are deliberately set opposite to what matters so
    // the decision must come from the latched flags.
    task automatic do_branch(input logic [15:0] v, input logic [2:0] wa, input logic [2:0] ra,
                             input logic [2:0] sa, input logic c, input logic n, input logic z,
                             input logic taken, input string nm);
        ctl_t e;
        fetch_decode(v, wa, ra, sa, nm);
        C = c; N = n; Z = z;
        e            = blank(4'd6);
        e.pc_ld      = taken;
        e.instr_done = 1'b1;
        expect_cycle(e, {nm, "_ex"});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        ctl_t e;
        reset = 1'b0;
        ir    = 16'h0000;
        C     = 1'b0;
        N     = 1'b0;
        Z     = 1'b0;
        @(posedge clk);
        #1;

        // Reset held for 3 cycles, then one RESET cycle before FETCH.
        repeat (3) expect_cycle(blank(4'd0), "in_reset");
        reset = 1'b1;
        expect_cycle(blank(4'd0), "reset_state");

        // ALU op 5, W=1 R=2 S=3; latches flags {C,N,Z} = {0,0,1}.
        do_alu(16'h0A53, 3'd1, 3'd2, 3'd3, 4'h5, 1'b0, 1'b0, 1'b1, "alu_z");
        // BEQ with latched Z=1, live Z=0 -> taken.
        do_branch(16'h42FC, 3'd3, 3'd7, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, "beq_taken");
        // ALU latches {1,0,0}.
        do_alu(16'h0A53, 3'd1, 3'd2, 3'd3, 4'h5, 1'b1, 1'b0, 1'b0, "alu_c");
        // BEQ with latched Z=0, live Z=1 -> not taken but still retires.
        do_branch(16'h42FC, 3'd3, 3'd7, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, "beq_not_taken");
        // BC: latched C=1, live C=0 -> taken.
        do_branch(16'h4605, 3'd0, 3'd0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, "bc_taken");
        // BN: latched N=0, live N=1 -> not taken.
        do_branch(16'h4805, 3'd0, 3'd0, 3'd5, 1'b0, 1'b1, 1'b0, 1'b0, "bn_not_taken");
        // BNE: latched Z=0, live Z=1 -> taken.
        do_branch(16'h4405, 3'd0, 3'd0, 3'd5, 1'b0, 1'b0, 1'b1, 1'b1, "bne_taken");
        // BR: always taken.
        do_branch(16'h4005, 3'd0, 3'd0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, "br");

        // LD W=2, R=3.
        fetch_decode(16'h2098, 3'd2, 3'd3, 3'd0, "ld");
        e            = blank(4'd4);
        e.adr_sel    = 1'b1;
        e.r_adr      = 3'd3;
        e.mr_en      = 1'b1;
        e.s_sel      = 1'b1;
        e.w_en       = 1'b1;
        e.w_adr      = 3'd2;
        e.instr_done = 1'b1;
        expect_cycle(e, "ld_ex");

        // ST R=3, S=2.
        fetch_decode(16'h221A, 3'd0, 3'd3, 3'd2, "st");
        e            = blank(4'd5);
        e.adr_sel    = 1'b1;
        e.r_adr      = 3'd3;
        e.s_adr      = 3'd2;
        e.mw_en      = 1'b1;
        e.instr_done = 1'b1;
        expect_cycle(e, "st_ex");

        // JR via S=5.
        fetch_decode(16'h5005, 3'd0, 3'd0, 3'd5, "jr");
        e            = blank(4'd7);
        e.s_adr      = 3'd5;
        e.pc_sel     = 1'b1;
        e.pc_ld      = 1'b1;
        e.instr_done = 1'b1;
        expect_cycle(e, "jr_ex");

        // Latch Z=1, then reset in the middle of a second ALU op.
        do_alu(16'h0A53, 3'd1, 3'd2, 3'd3, 4'h5, 1'b0, 1'b0, 1'b1, "alu_pre_rst");
        fetch_decode(16'h0A53, 3'd1, 3'd2, 3'd3, "alu_rst");
        C = 1'b0; N = 1'b0; Z = 1'b1;
        exp_q.push_back(alu_word(3'd1, 3'd2, 3'd3, 4'h5));
        name_q.push_back("alu_rst_ex");
        @(negedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        expect_cycle(blank(4'd0), "rst_mid_alu");
        reset = 1'b1;
        expect_cycle(blank(4'd0), "rst_mid_release");
        // Flags were cleared: BEQ with live Z=1 must not be taken.
        do_branch(16'h42FC, 3'd3, 3'd7, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, "beq_after_rst");

        // HALT holds for 10 cycles with all outputs low.
        fetch_decode(16'hFE00, 3'd0, 3'd0, 3'd0, "halt");
        repeat (10) expect_cycle(blank(4'd8), "halt_hold");

        // Reset out of HALT, then an illegal opcode.
        reset = 1'b0;
        expect_cycle(blank(4'd0), "halt_reset");
        reset = 1'b1;
        expect_cycle(blank(4'd0), "halt_reset_release");
        fetch_decode(16'h6000, 3'd0, 3'd0, 3'd0, "ill");
        e         = blank(4'd9);
        e.illegal = 1'b1;
        repeat (6) expect_cycle(e, "illegal_hold");
        reset = 1'b0;
        expect_cycle(blank(4'd0), "illegal_reset");
        reset = 1'b1;

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_cu.md
Name: cpu_cu

Overview:
Control unit that sits directly upstream of the CPU execution unit and drives every one of its control inputs. It fetches a 16-bit instruction, decodes it, and sequences a multi-cycle FETCH/DECODE/EXECUTE state machine. It holds the latched status flags used for conditional branches and steps the program counter.

Parameters:
ALU_PASS_S, 4'h0, Alu_Op code that passes the S operand to D_out unchanged.
RESET_STATE_CODE, 4'h0, encoding of the RESET state on dbg_state.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous active-low reset.
ir  in  16  instruction register contents from the EU.
C  in  1  ALU carry from the EU.
N  in  1  ALU negative from the EU.
Z  in  1  ALU zero from the EU.
ir_ld  out  1  load instruction register.
pc_inc  out  1  increment PC.
pc_ld  out  1  load PC from the PC mux.
pc_sel  out  1  PC mux select: 1 = D_out, 0 = PC + sign-extended ir[7:0].
adr_sel  out  1  address mux select: 1 = register address, 0 = PC.
W_En  out  1  register-file write enable.
S_Sel  out  1  S operand select: 1 = memory data, 0 = register.
W_Adr  out  3  register-file write address.
R_Adr  out  3  register-file R read address.
S_Adr  out  3  register-file S read address.
Alu_Op  out  4  ALU operation.
mr_en  out  1  memory read enable.
mw_en  out  1  memory write enable.
instr_done  out  1  one-cycle pulse on each retired instruction.
illegal  out  1  sticky illegal-opcode indicator.
dbg_state  out  4  current state encoding.

Behaviour:
- Instruction fields:
  - op = ir[15:9]; wa = ir[8:6]; ra = ir[5:3]; sa = ir[2:0]; off = ir[7:0].
  - op 7'h00–7'h0F: ALU op, Alu_Op = op[3:0].
  - 7'h10 LD; 7'h11 ST.
  - 7'h20 BR; 7'h21 BEQ (Z); 7'h22 BNE (!Z); 7'h23 BC (C); 7'h24 BN (N).
  - 7'h28 JR; 7'h7F HALT.
  - Any other op is illegal.
- State register and flag register flags_q{C,N,Z} are the only sequential elements. All outputs are combinational decode of state and ir. Every output not listed for a state is 0.
- Reset: asynchronous. state = RESET, flags_q = 0, illegal = 0. Outputs go to 0 immediately, including mid-instruction. A partial instruction is abandoned with no write.
- RESET: all outputs 0; next state FETCH.
- FETCH: adr_sel=0, mr_en=1, ir_ld=1, pc_inc=1; next state DECODE.
- DECODE: no side effects. W_Adr/R_Adr/S_Adr are driven from the fields. Next state by op: EX_ALU, EX_LD, EX_ST, EX_BR, EX_JR, HALT, or ILLEGAL.
- EX_ALU: W_En=1, S_Sel=0, Alu_Op=op[3:0], W_Adr=wa, R_Adr=ra, S_Adr=sa. At the clock edge flags_q <= {C,N,Z}. instr_done=1. Next state FETCH.
- EX_LD: adr_sel=1, R_Adr=ra, mr_en=1, S_Sel=1, Alu_Op=ALU_PASS_S, W_En=1, W_Adr=wa. Flags unchanged. instr_done=1. Next state FETCH.
- EX_ST: adr_sel=1, R_Adr=ra, S_Adr=sa, S_Sel=0, Alu_Op=ALU_PASS_S, mw_en=1. Flags unchanged. instr_done=1. Next state FETCH.
- EX_BR: pc_sel=0. pc_ld = 1 for BR, otherwise the condition evaluated on flags_q (not on live C/N/Z). The offset is relative to the already-incremented PC (PC+1). instr_done=1. Next state FETCH.
- EX_JR: S_Adr=sa, S_Sel=0, Alu_Op=ALU_PASS_S, pc_sel=1, pc_ld=1. instr_done=1. Next state FETCH.
- HALT: all outputs 0; stays in HALT until reset.
- ILLEGAL: illegal=1 (sticky), all other outputs 0; stays in ILLEGAL until reset.
- Timing: 3 cycles per instruction (FETCH, DECODE, EX).
- Invariants:
  - pc_inc and pc_ld are never high in the same cycle.
  - mr_en and mw_en are never high together.
  - W_En and mw_en are never high together.
- A not-taken branch still retires: instr_done=1, pc_ld=0.
- State encoding on dbg_state: RESET=0, FETCH=1, DECODE=2, EX_ALU=3, EX_LD=4, EX_ST=5, EX_BR=6, EX_JR=7, HALT=8, ILLEGAL=9.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release. Required: all outputs 0 during reset; dbg_state=0 then 1; the FETCH cycle shows ir_ld=pc_inc=mr_en=1.
- ALU op: ir=16'h0A53 (op 7'h05). Required: EX_ALU shows Alu_Op=4'h5, W_Adr=1, R_Adr=2, S_Adr=3, W_En=1, instr_done=1; the edge after EX_ALU latches flags_q={C,N,Z}={0,0,1}.
- Conditional branch: BEQ ir=16'h42FC with flags_q.Z=1. Required: pc_ld=1, pc_sel=0. Repeat with Z=0: pc_ld=0, instr_done=1, next state FETCH.
- Memory ops: LD ir=16'h2098. Required: adr_sel=1, R_Adr=3, S_Sel=1, W_En=1, W_Adr=2, mr_en=1. ST ir=16'h221A. Required: mw_en=1, W_En=0, R_Adr=3, S_Adr=2.
- Illegal and halt: ir=16'hFE00 (HALT). Required: dbg_state=8 and all outputs 0 for 10 cycles. Separately, ir=16'h6000 (illegal). Required: illegal=1 held until reset.
- Reset mid-instruction: assert reset during EX_ALU. Required: W_En drops immediately, flags_q=0, and the next state after release is FETCH.
